// File: rtl/call_stack.sv
// LIFO call stack, DEPTH x WIDTH; count is the next-free pointer and dout is the top entry (combinational).
// Zero latency: push/pop/replace take effect at the edge and dout/count/full/empty follow immediately; no backpressure, full push and empty pop are dropped without wrap.
// Sticky overflow/underflow flags exist only when CALL_STACK_ERR_FLAGS_EN is defined; otherwise they read 0.
module call_stack #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    input  logic                       clr_err,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]    count_q;
    logic [AW-1:0]    top_idx;
    logic [AW-1:0]    free_idx;

    logic             do_replace;
    logic             do_push;
    logic             do_pop;
    logic             wr_en;
    logic [AW-1:0]    wr_idx;
    logic [CW-1:0]    count_d;

    assign count    = count_q;
    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
    assign top_idx  = AW'(count_q - CW'(1));
    assign free_idx = AW'(count_q);

    // Entries are never read while empty, so stale contents after reset are harmless.
    assign dout = empty ? '0 : mem[top_idx];

    // Push+pop on an empty stack degrades to a plain push.
    always_comb begin
        do_replace = push && pop && !empty;
        do_push    = push && !full && (!pop || empty);
        do_pop     = pop && !push && !empty;
        wr_en      = (do_replace || do_push) && reset;
        wr_idx     = do_replace ? top_idx : free_idx;
        count_d    = count_q;
        if (do_push) begin
            count_d = count_q + CW'(1);
        end else if (do_pop) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Storage has no reset; writes are gated off while reset is held.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= din;
        end
    end

`ifdef CALL_STACK_ERR_FLAGS_EN
    logic ovf_set;
    logic unf_set;

    assign ovf_set = push && !pop && full;
    assign unf_set = pop && !push && empty;

    // A same-cycle error wins over clr_err.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (unf_set) begin
                underflow <= 1'b1;
            end else if (clr_err) begin
                underflow <= 1'b0;
            end
        end
    end
`else
    logic unused_clr_err;

    assign unused_clr_err = clr_err;
    assign overflow       = 1'b0;
    assign underflow      = 1'b0;
`endif

endmodule

// File: tb/tb_call_stack.sv
// Directed bench for call_stack (WIDTH=10, DEPTH=8); flag expectations follow CALL_STACK_ERR_FLAGS_EN.
module tb_call_stack;

`ifdef CALL_STACK_ERR_FLAGS_EN
    localparam logic FLG = 1'b1;
`else
    localparam logic FLG = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic       push;
    logic       pop;
    logic [9:0] din;
    logic       clr_err;
    logic [9:0] dout;
    logic [3:0] count;
    logic       full;
    logic       empty;
    logic       overflow;
    logic       underflow;

    int checks;
    int failures;

    call_stack #(.WIDTH(10), .DEPTH(8)) dut (
        .clk(clk),
        .reset(reset),
        .push(push),
        .pop(pop),
        .din(din),
        .clr_err(clr_err),
        .dout(dout),
        .count(count),
        .full(full),
        .empty(empty),
        .overflow(overflow),
        .underflow(underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock with the given request; inputs change 1 time unit after the edge.
    task automatic cyc(input logic p, input logic q, input logic [9:0] d, input logic c);
        push    = p;
        pop     = q;
        din     = d;
        clr_err = c;
        @(posedge clk);
        #1;
        push    = 1'b0;
        pop     = 1'b0;
        clr_err = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        push = 1'b0; pop = 1'b0; din = '0; clr_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (empty !== 1'b1 || full !== 1'b0) begin failures++; $display("FAIL reset_status got empty=%b full=%b exp 1 0", empty, full); end
        checks++; if (dout !== 10'h000) begin failures++; $display("FAIL reset_dout got=%h exp=000", dout); end
        checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin failures++; $display("FAIL reset_flags got=%b%b exp=00", overflow, underflow); end
        reset = 1'b1;
        #2;
    endtask

    task automatic test_push_pop();
        cyc(1, 0, 10'h001, 0);
        cyc(1, 0, 10'h002, 0);
        cyc(1, 0, 10'h003, 0);
        checks++; if (count !== 4'd3 || dout !== 10'h003) begin failures++; $display("FAIL pp_push got count=%0d dout=%h exp 3 003", count, dout); end
        cyc(0, 1, 10'h000, 0);
        checks++; if (dout !== 10'h002) begin failures++; $display("FAIL pp_pop1 got=%h exp=002", dout); end
        cyc(0, 1, 10'h000, 0);
        checks++; if (dout !== 10'h001) begin failures++; $display("FAIL pp_pop2 got=%h exp=001", dout); end
        cyc(0, 1, 10'h000, 0);
        checks++; if (dout !== 10'h000 || empty !== 1'b1 || count !== 4'd0) begin failures++; $display("FAIL pp_pop3 got dout=%h empty=%b count=%0d exp 000 1 0", dout, empty, count); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 8; i++) cyc(1, 0, 10'(16 + i), 0);
        checks++; if (full !== 1'b1 || count !== 4'd8 || dout !== 10'h017) begin failures++; $display("FAIL ovf_fill got full=%b count=%0d dout=%h exp 1 8 017", full, count, dout); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_early got=%b exp=0", overflow); end
        cyc(1, 0, 10'h3FF, 0);
        checks++; if (count !== 4'd8 || dout !== 10'h017) begin failures++; $display("FAIL ovf_hold got count=%0d dout=%h exp 8 017", count, dout); end
        checks++; if (overflow !== FLG) begin failures++; $display("FAIL ovf_flag got=%b exp=%b", overflow, FLG); end
        cyc(0, 0, 10'h000, 1);
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clr got=%b exp=0", overflow); end
        cyc(1, 1, 10'h2AA, 0);
        checks++; if (count !== 4'd8 || dout !== 10'h2AA || overflow !== 1'b0) begin failures++; $display("FAIL full_replace got count=%0d dout=%h ovf=%b exp 8 2aa 0", count, dout, overflow); end
        cyc(0, 1, 10'h000, 0);
        checks++; if (dout !== 10'h016) begin failures++; $display("FAIL ovf_nowrap got=%h exp=016", dout); end
        for (int i = 0; i < 7; i++) begin
            cyc(0, 1, 10'h000, 0);
            checks++; if (dout !== ((i < 6) ? 10'(21 - i) : 10'h000)) begin failures++; $display("FAIL ovf_drain%0d got=%h", i, dout); end
        end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL ovf_empty got=%b exp=1", empty); end
    endtask

    task automatic test_underflow();
        cyc(0, 1, 10'h000, 0);
        checks++; if (count !== 4'd0 || underflow !== FLG) begin failures++; $display("FAIL unf_set got count=%0d unf=%b exp 0 %b", count, underflow, FLG); end
        cyc(0, 0, 10'h000, 1);
        checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL unf_clr got=%b exp=0", underflow); end
        cyc(0, 1, 10'h000, 1);
        checks++; if (underflow !== FLG || count !== 4'd0) begin failures++; $display("FAIL unf_setwins got unf=%b count=%0d exp %b 0", underflow, count, FLG); end
        cyc(0, 0, 10'h000, 1);
        checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL unf_clr2 got=%b exp=0", underflow); end
    endtask

    task automatic test_replace();
        cyc(1, 0, 10'h004, 0);
        cyc(1, 0, 10'h005, 0);
        checks++; if (count !== 4'd2 || dout !== 10'h005) begin failures++; $display("FAIL rep_setup got count=%0d dout=%h exp 2 005", count, dout); end
        cyc(1, 1, 10'h0AA, 0);
        checks++; if (count !== 4'd2 || dout !== 10'h0AA) begin failures++; $display("FAIL rep_inplace got count=%0d dout=%h exp 2 0aa", count, dout); end
        cyc(0, 1, 10'h000, 0);
        checks++; if (dout !== 10'h004) begin failures++; $display("FAIL rep_below got=%h exp=004", dout); end
        cyc(0, 1, 10'h000, 0);
        cyc(1, 1, 10'h055, 0);
        checks++; if (count !== 4'd1 || dout !== 10'h055 || underflow !== 1'b0) begin failures++; $display("FAIL rep_empty got count=%0d dout=%h unf=%b exp 1 055 0", count, dout, underflow); end
    endtask

    task automatic test_reset_mid();
        cyc(1, 0, 10'h101, 0);
        cyc(1, 0, 10'h102, 0);
        cyc(1, 0, 10'h103, 0);
        checks++; if (count !== 4'd4) begin failures++; $display("FAIL rst_setup got=%0d exp=4", count); end
        #2;
        push = 1'b1; din = 10'h1FF;
        reset = 1'b0;
        #1;
        checks++; if (count !== 4'd0 || empty !== 1'b1 || dout !== 10'h000) begin failures++; $display("FAIL rst_async got count=%0d empty=%b dout=%h exp 0 1 000", count, empty, dout); end
        checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin failures++; $display("FAIL rst_flags got=%b%b exp=00", overflow, underflow); end
        @(posedge clk);
        #1;
        checks++; if (count !== 4'd0) begin failures++; $display("FAIL rst_discard got=%0d exp=0", count); end
        push = 1'b0;
        #2;
        reset = 1'b1;
        cyc(1, 0, 10'h123, 0);
        checks++; if (count !== 4'd1 || dout !== 10'h123) begin failures++; $display("FAIL rst_after got count=%0d dout=%h exp 1 123", count, dout); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_push_pop();
        test_overflow();
        test_underflow();
        test_replace();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
